// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin CPU/debug-unit arbiter for one shared single-port memory
// Three-state FSM (IDLE/BUSY/DONE); the winner's request is latched so later request changes cannot disturb it.
module mem_port_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_ack,
    output logic [31:0]       cpu_rdata,
    output logic              mdr_we,
    input  logic              dbu_req,
    input  logic [31:0]       dbu_addr,
    output logic              dbu_ack,
    output logic [31:0]       dbu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DBU = 1'b1;

    state_t             state_q;
    logic [1:0]         cnt_q;
    logic               owner_q;
    logic               last_grant_q;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rbuf_q;
    logic               busy_q;
    logic               cpu_ack_q;
    logic               dbu_ack_q;
    logic               mdr_we_q;
    logic               mem_we_q;

    logic               grant_dbu_d;
    logic               any_req_d;
    logic               unused_addr_bits;

    // On a tie the requester that did not win last time gets the port.
    assign any_req_d   = cpu_req | dbu_req;
    assign grant_dbu_d = dbu_req & (~cpu_req | (last_grant_q == OWNER_CPU));

    assign unused_addr_bits = ^{cpu_addr[1:0], dbu_addr[1:0],
                                cpu_addr[31:ADDR_W+2], dbu_addr[31:ADDR_W+2]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            owner_q      <= OWNER_CPU;
            last_grant_q <= OWNER_DBU;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 32'd0;
            rbuf_q       <= 32'd0;
            busy_q       <= 1'b0;
            cpu_ack_q    <= 1'b0;
            dbu_ack_q    <= 1'b0;
            mdr_we_q     <= 1'b0;
            mem_we_q     <= 1'b0;
        end else begin
            cpu_ack_q <= 1'b0;
            dbu_ack_q <= 1'b0;
            mdr_we_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req_d) begin
                        owner_q      <= grant_dbu_d;
                        last_grant_q <= grant_dbu_d;
                        addr_q       <= grant_dbu_d ? dbu_addr[ADDR_W+1:2] : cpu_addr[ADDR_W+1:2];
                        we_q         <= ~grant_dbu_d & cpu_we;
                        wdata_q      <= grant_dbu_d ? 32'd0 : cpu_wdata;
                        mem_we_q     <= ~grant_dbu_d & cpu_we;
                        cnt_q        <= 2'd0;
                        busy_q       <= 1'b1;
                        state_q      <= BUSY;
                    end
                end
                BUSY: begin
                    if (we_q || (cnt_q == 2'(READ_LAT))) begin
                        if (!we_q) begin
                            rbuf_q <= mem_rdata;
                        end
                        cpu_ack_q <= (owner_q == OWNER_CPU);
                        dbu_ack_q <= (owner_q == OWNER_DBU);
                        mdr_we_q  <= (owner_q == OWNER_CPU) & ~we_q;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Outputs are forced low for as long as rst is held, not just after its edge.
    assign busy      = ~rst & busy_q;
    assign cpu_ack   = ~rst & cpu_ack_q;
    assign dbu_ack   = ~rst & dbu_ack_q;
    assign mdr_we    = ~rst & mdr_we_q;
    assign mem_we    = ~rst & mem_we_q;
    assign mem_addr  = (rst || !busy_q) ? '0 : addr_q;
    assign mem_wdata = (rst || !busy_q) ? 32'd0 : wdata_q;
    assign cpu_rdata = rst ? 32'd0 : rbuf_q;
    assign dbu_rdata = rst ? 32'd0 : rbuf_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter at READ_LAT 1 and 3
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, dbu_req;
    logic [31:0] cpu_addr, cpu_wdata, dbu_addr;

    logic        a_cpu_ack, a_mdr_we, a_dbu_ack, a_mem_we, a_busy;
    logic [31:0] a_cpu_rdata, a_dbu_rdata, a_mem_wdata, a_mem_rdata;
    logic [7:0]  a_mem_addr;

    logic        b_cpu_ack, b_mdr_we, b_dbu_ack, b_mem_we, b_busy;
    logic [31:0] b_cpu_rdata, b_dbu_rdata, b_mem_wdata, b_mem_rdata;
    logic [7:0]  b_mem_addr;

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic [31:0] b_p1, b_p2;

    int total = 0;
    int bad   = 0;

    logic        ca [32], da [32], md [32], mw [32], bz [32];
    logic [31:0] cr [32], dr [32], ma [32], mwd [32];
    logic        bda [32], bmd [32], bbz [32];
    logic [31:0] bdr [32], bma [32];

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(8), .READ_LAT(1)) dut_a (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(a_cpu_ack), .cpu_rdata(a_cpu_rdata), .mdr_we(a_mdr_we),
        .dbu_req(dbu_req), .dbu_addr(dbu_addr), .dbu_ack(a_dbu_ack), .dbu_rdata(a_dbu_rdata),
        .mem_addr(a_mem_addr), .mem_we(a_mem_we), .mem_wdata(a_mem_wdata),
        .mem_rdata(a_mem_rdata), .busy(a_busy)
    );

    mem_port_arbiter #(.ADDR_W(8), .READ_LAT(3)) dut_b (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata), .mdr_we(b_mdr_we),
        .dbu_req(dbu_req), .dbu_addr(dbu_addr), .dbu_ack(b_dbu_ack), .dbu_rdata(b_dbu_rdata),
        .mem_addr(b_mem_addr), .mem_we(b_mem_we), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    function automatic logic [31:0] memf(input int i);
        return (i == 4) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | 32'(i));
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= memf(i);
        end else if (a_mem_we) begin
            mem_a[a_mem_addr] <= a_mem_wdata;
        end
        a_mem_rdata <= mem_a[a_mem_addr];
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem_b[i] <= memf(i);
        end else if (b_mem_we) begin
            mem_b[b_mem_addr] <= b_mem_wdata;
        end
        b_p1        <= mem_b[b_mem_addr];
        b_p2        <= b_p1;
        b_mem_rdata <= b_p2;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; cpu_req = 1'b0; dbu_req = 1'b0; cpu_we = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // Cycle 0 is the cycle in which the caller raised the request(s).
    task automatic run(input int n, input bit keep, input int dbu_rise);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ca[i] = a_cpu_ack; da[i] = a_dbu_ack; md[i] = a_mdr_we; mw[i] = a_mem_we;
            bz[i] = a_busy; cr[i] = a_cpu_rdata; dr[i] = a_dbu_rdata;
            ma[i] = 32'(a_mem_addr); mwd[i] = a_mem_wdata;
            bda[i] = b_dbu_ack; bmd[i] = b_mdr_we; bbz[i] = b_busy;
            bdr[i] = b_dbu_rdata; bma[i] = 32'(b_mem_addr);
            cyc();
            if (i == 0 && !keep) begin
                cpu_req = 1'b0;
                dbu_req = 1'b0;
            end
            if (i + 1 == dbu_rise) dbu_req = 1'b1;
        end
    endtask

    initial begin
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; dbu_req = 1'b0;
        cpu_addr = 32'd0; cpu_wdata = 32'd0; dbu_addr = 32'd0;
        cyc();
        @(negedge clk);
        chk("rst_busy", {31'd0, a_busy}, 32'd0);
        chk("rst_cpu_ack", {31'd0, a_cpu_ack}, 32'd0);
        chk("rst_mem_addr", 32'(a_mem_addr), 32'd0);
        chk("rst_mem_wdata", a_mem_wdata, 32'd0);
        chk("rst_cpu_rdata", a_cpu_rdata, 32'd0);
        chk("rst_dbu_rdata", a_dbu_rdata, 32'd0);
        cyc();
        rst = 1'b0;

        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0010;
        run(5, 1'b0, 0);
        chk("rd_busy0", {31'd0, bz[0]}, 32'd0);
        chk("rd_maddr1", ma[1], 32'd4);
        chk("rd_ack2", {31'd0, ca[2]}, 32'd0);
        chk("rd_ack3", {31'd0, ca[3]}, 32'd1);
        chk("rd_mdr3", {31'd0, md[3]}, 32'd1);
        chk("rd_data3", cr[3], 32'hDEAD_BEEF);
        chk("rd_ack4", {31'd0, ca[4]}, 32'd0);
        chk("rd_busy4", {31'd0, bz[4]}, 32'd0);
        for (int i = 0; i < 5; i++) chk($sformatf("rd_dbu_ack%0d", i), {31'd0, da[i]}, 32'd0);

        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0008; cpu_wdata = 32'h1234_5678;
        run(5, 1'b0, 0);
        cpu_we = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("wr_mem_we%0d", i), {31'd0, mw[i]}, (i == 1) ? 32'd1 : 32'd0);
            chk($sformatf("wr_ack%0d", i), {31'd0, ca[i]}, (i == 2) ? 32'd1 : 32'd0);
            chk($sformatf("wr_mdr%0d", i), {31'd0, md[i]}, 32'd0);
        end
        chk("wr_maddr1", ma[1], 32'd2);
        chk("wr_wdata1", mwd[1], 32'h1234_5678);
        chk("wr_rbuf_kept", cr[2], 32'hDEAD_BEEF);

        cpu_req = 1'b1; cpu_addr = 32'h0000_0008;
        run(5, 1'b0, 0);
        chk("rb_ack3", {31'd0, ca[3]}, 32'd1);
        chk("rb_mdr3", {31'd0, md[3]}, 32'd1);
        chk("rb_data3", cr[3], 32'h1234_5678);

        do_reset();
        cpu_req = 1'b1; cpu_addr = 32'h0000_0010; dbu_req = 1'b1; dbu_addr = 32'h0000_0014;
        run(17, 1'b1, 0);
        cpu_req = 1'b0; dbu_req = 1'b0;
        for (int i = 0; i < 17; i++) begin
            chk($sformatf("rr_cpu_ack%0d", i), {31'd0, ca[i]}, (i == 3 || i == 11) ? 32'd1 : 32'd0);
            chk($sformatf("rr_dbu_ack%0d", i), {31'd0, da[i]}, (i == 7 || i == 15) ? 32'd1 : 32'd0);
        end
        chk("rr_dbu_data7", dr[7], 32'hC0DE_0005);
        chk("rr_cpu_data11", cr[11], 32'hDEAD_BEEF);
        chk("rr_dbu_mdr7", {31'd0, md[7]}, 32'd0);

        do_reset();
        dbu_req = 1'b1; dbu_addr = 32'h0000_0014;
        run(7, 1'b0, 0);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("l3_busy%0d", i), {31'd0, bbz[i]}, (i >= 1 && i <= 5) ? 32'd1 : 32'd0);
            chk($sformatf("l3_ack%0d", i), {31'd0, bda[i]}, (i == 5) ? 32'd1 : 32'd0);
            chk($sformatf("l3_mdr%0d", i), {31'd0, bmd[i]}, 32'd0);
        end
        chk("l3_maddr1", bma[1], 32'd5);
        chk("l3_data5", bdr[5], 32'hC0DE_0005);

        do_reset();
        cpu_req = 1'b1; cpu_addr = 32'h0000_0010;
        cyc();
        cpu_req = 1'b0;
        cyc();
        rst = 1'b1;
        @(negedge clk);
        chk("ab_inrst_busy", {31'd0, a_busy}, 32'd0);
        chk("ab_inrst_maddr", 32'(a_mem_addr), 32'd0);
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("ab_busy%0d", i), {31'd0, a_busy}, 32'd0);
            chk($sformatf("ab_ack%0d", i), {31'd0, a_cpu_ack}, 32'd0);
            chk($sformatf("ab_mdr%0d", i), {31'd0, a_mdr_we}, 32'd0);
            chk($sformatf("ab_rdata%0d", i), a_cpu_rdata, 32'd0);
            cyc();
        end
        cpu_req = 1'b1;
        run(5, 1'b0, 0);
        chk("ab_next_ack3", {31'd0, ca[3]}, 32'd1);
        chk("ab_next_data3", cr[3], 32'hDEAD_BEEF);

        do_reset();
        cpu_req = 1'b1; cpu_addr = 32'h0000_0010; dbu_addr = 32'h0000_0014;
        run(9, 1'b0, 1);
        dbu_req = 1'b0;
        chk("ov_maddr2", ma[2], 32'd4);
        chk("ov_cpu_data3", cr[3], 32'hDEAD_BEEF);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("ov_cpu_ack%0d", i), {31'd0, ca[i]}, (i == 3) ? 32'd1 : 32'd0);
            chk($sformatf("ov_dbu_ack%0d", i), {31'd0, da[i]}, (i == 7) ? 32'd1 : 32'd0);
        end
        chk("ov_dbu_maddr5", ma[5], 32'd5);
        chk("ov_dbu_data7", dr[7], 32'hC0DE_0005);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the word-address width of the shared memory.
REQ-002 The block SHALL have parameter READ_LAT, default 1, legal 1..3, meaning the cycles from the first presentation of mem_addr until mem_rdata is valid.
REQ-003 The block SHALL run on one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 cpu_req  input  1  level request from the CPU datapath.
REQ-007 cpu_we  input  1  1 = write, 0 = read; sampled with cpu_req.
REQ-008 cpu_addr  input  32  byte address; bits [1:0] are ignored.
REQ-009 cpu_wdata  input  32  write data.
REQ-010 cpu_ack  output  1  one-cycle completion pulse to the CPU.
REQ-011 cpu_rdata  output  32  read data; valid while cpu_ack is high.
REQ-012 mdr_we  output  1  load enable for the CPU memory data register; pulses with cpu_ack on CPU reads only.
REQ-013 dbu_req  input  1  level read request from the debug unit (DBU); the DBU has no write port.
REQ-014 dbu_addr  input  32  byte address; bits [1:0] are ignored.
REQ-015 dbu_ack  output  1  one-cycle completion pulse to the DBU.
REQ-016 dbu_rdata  output  32  read data; valid while dbu_ack is high.
REQ-017 mem_addr  output  ADDR_W  word address, driven as latched_addr[ADDR_W+1:2].
REQ-018 mem_we  output  1  memory write strobe.
REQ-019 mem_wdata  output  32  latched write data.
REQ-020 mem_rdata  input  32  memory read data.
REQ-021 busy  output  1  high whenever state != IDLE.

Function
REQ-022 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-023 In IDLE with any request pending, the block SHALL at the clock edge:
- latch the owner, address, we and wdata of the winning requester;
- clear cnt to 0;
- move to BUSY.
REQ-024 Arbitration SHALL be round-robin over a last_grant register.
- Only one requester pending: it wins.
- Both pending: the requester not equal to last_grant wins.
- last_grant updates on every grant.
REQ-025 In BUSY and DONE, mem_addr and mem_wdata SHALL be driven from the latched values; in IDLE they SHALL be 0.
REQ-026 mem_we SHALL be 1 only in the BUSY cycle with cnt==0 of a CPU write.
REQ-027 A write SHALL spend one BUSY cycle and then move to DONE.
REQ-028 A read SHALL count cnt upward once per BUSY cycle.
- At cnt==READ_LAT, mem_rdata is captured into rbuf and the FSM moves to DONE.
- A read therefore spends READ_LAT+1 cycles in BUSY.
REQ-029 DONE SHALL last exactly one cycle and then return to IDLE.
- The owner's ack is 1 during DONE.
- mdr_we is 1 during DONE if the owner is the CPU and the access is a read.
REQ-030 cpu_rdata and dbu_rdata SHALL both equal rbuf.
- rbuf holds its value until the next read capture.
- rbuf is unchanged by writes.
REQ-031 Requests are level-sensitive; a req still high in the IDLE cycle after ack SHALL be treated as a new request.
REQ-032 Requests changing during BUSY or DONE SHALL have no effect on the transfer in progress.
REQ-033 Latency with the request first high in cycle 0 in IDLE:
- read ack in cycle READ_LAT+2;
- write ack in cycle 2.
REQ-034 A requester not granted SHALL see no ack and SHALL be served in the next IDLE arbitration if its req is still high.

Reset
REQ-035 When rst is high at a clock edge, the block SHALL set:
- state = IDLE, cnt = 0, rbuf = 0, latches = 0;
- last_grant = DBU, so the CPU wins the first tie.
REQ-036 While in reset, all outputs SHALL be 0 (cpu_ack, dbu_ack, mdr_we, mem_we, busy, mem_addr, mem_wdata, cpu_rdata, dbu_rdata).
REQ-037 A reset during BUSY or DONE SHALL abort the access: no ack and no mdr_we are issued for it.

Verification
REQ-038 CPU read, READ_LAT=1, cpu_addr=0x0000_0010, mem word 4 = 0xDEAD_BEEF -> mem_addr=4; cpu_ack, mdr_we and cpu_rdata=0xDEAD_BEEF in cycle 3; dbu_ack stays 0.
REQ-039 CPU write, cpu_addr=0x0000_0008, wdata=0x1234_5678 -> mem_we=1 for one cycle (cycle 1) with mem_addr=2; cpu_ack in cycle 2; mdr_we stays 0.
REQ-040 cpu_req and dbu_req both held high after reset -> grants in the order CPU, DBU, CPU, DBU; each ack is a single cycle.
REQ-041 READ_LAT=3, DBU read of word 0x05 -> BUSY for 4 cycles; dbu_ack in cycle 5 with the correct data; mdr_we stays 0.
REQ-042 rst asserted in the second BUSY cycle of a CPU read -> next cycle is IDLE with all outputs 0; no ack; a following read completes normally.
REQ-043 dbu_req pulsed while a CPU access is in BUSY, then held -> the DBU is served immediately after the CPU's DONE; the CPU transfer is unaffected.
